menu_input_ctrl: RTL and testbench

Conditions the raw left/right/decide push-buttons for the battle-menu stage.
- Synchronizes and debounces each button.
- Encodes left/right into the 2-bit key code the menu consumes, and drives a clean decide level.
- Sits between the board button pins and the menu block. The menu acts only on 00->nonzero key transitions and 0->1 decide transitions, so this block must never emit glitches or spurious edges.

---
 rtl/menu_input_pkg.sv | 28 ++
 rtl/button_debounce.sv | 44 ++++
 rtl/menu_input_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_menu_input_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/menu_input_pkg.sv
// Shared key-code definitions for the battle-menu input path.
// Used by menu_input_ctrl, the menu block and the game-state logic.
package menu_input_pkg;

  typedef logic [1:0] key_code_t;

  localparam key_code_t KEY_NONE  = 2'b00;
  localparam key_code_t KEY_RIGHT = 2'b01;
  localparam key_code_t KEY_LEFT  = 2'b10;

  // Button slots in the per-button vectors of menu_input_ctrl
  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_DECIDE = 2;
  localparam int BTN_COUNT  = 3;

  // Both or neither direction maps to KEY_NONE, so 2'b11 is never produced
  function automatic key_code_t encode_keys(input logic left, input logic right);
    key_code_t code;
    case ({left, right})
      2'b01:   code = KEY_RIGHT;
      2'b10:   code = KEY_LEFT;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one push-button.
// A change of the synchronized level is accepted only after it has persisted
// for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic stable_out
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_reg;
  logic          sync_reg;
  logic          stable_reg;
  logic [CW-1:0] count_reg;

  // Synchronize the raw pin, then qualify each change with the debounce counter
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg   <= 1'b0;
      sync_reg   <= 1'b0;
      stable_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      meta_reg <= raw_in;
      sync_reg <= meta_reg;
      if (sync_reg == stable_reg) begin
        count_reg <= '0;
      end else if (count_reg == COUNT_LAST) begin
        stable_reg <= sync_reg;
        count_reg  <= '0;
      end else begin
        count_reg <= count_reg + CW'(1);
      end
    end
  end

  assign stable_out = stable_reg;

endmodule

// File: rtl/menu_input_ctrl.sv
// Button conditioning for the battle menu: debounces left/right/decide,
// encodes the direction key code and drives a clean decide level.
// Optional build macro AUTO_REPEAT_EN adds auto-repeat of a held direction.
module menu_input_ctrl
  import menu_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned REPEAT_DELAY    = 32500000,
  parameter int unsigned REPEAT_PERIOD   = 9750000,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      btn_left_in,
  input  logic      btn_right_in,
  input  logic      btn_decide_in,
  input  logic      enable_in,
  output key_code_t key_input_out,
  output logic      decide_out
);

  // Zero-length timings would make the counters below meaningless
  if ((DEBOUNCE_CYCLES < 1) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1) || (GAP_CYCLES < 1)) begin : g_bad_params
    $error("menu_input_ctrl: all timing parameters must be at least 1");
  end

  // After reset the stable values read 0 regardless of the pins. Arming waits
  // until the debouncers have had time to re-acquire a held button, so a press
  // that spans a reset is not mistaken for a fresh one.
  localparam int unsigned SETTLE = DEBOUNCE_CYCLES + 3;
  localparam int unsigned SW     = $clog2(SETTLE + 1);

  logic [BTN_COUNT-1:0] raw;
  logic [BTN_COUNT-1:0] stable;
  logic [BTN_COUNT-1:0] pressed;
  logic [BTN_COUNT-1:0] armed_reg;
  logic [BTN_COUNT-1:0] armed_next;
  logic [SW-1:0]        settle_reg;
  logic                 settle_done;
  key_code_t            base_code;
  key_code_t            key_reg;
  key_code_t            key_next;
  logic                 decide_reg;
  logic                 decide_next;

  assign raw[BTN_RIGHT]  = btn_right_in;
  assign raw[BTN_LEFT]   = btn_left_in;
  assign raw[BTN_DECIDE] = btn_decide_in;

  genvar gi;
  generate
    for (gi = 0; gi < BTN_COUNT; gi++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (raw[gi]),
        .stable_out(stable[gi])
      );

      // A button arms once seen released while the menu is enabled
      always_comb begin
        armed_next[gi] = armed_reg[gi];
        if (!enable_in) begin
          armed_next[gi] = 1'b0;
        end else if (settle_done && !stable[gi]) begin
          armed_next[gi] = 1'b1;
        end
      end

      assign pressed[gi] = stable[gi] & armed_reg[gi];
    end
  endgenerate

  assign settle_done = (settle_reg == SW'(SETTLE));

  // Post-reset settle counter and arming flags
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_reg <= '0;
      armed_reg  <= '0;
    end else begin
      if (!settle_done) begin
        settle_reg <= settle_reg + SW'(1);
      end
      armed_reg <= armed_next;
    end
  end

  // Key code and decide level the menu should see, before any repeat shaping
  always_comb begin
    base_code   = KEY_NONE;
    decide_next = 1'b0;
    if (enable_in) begin
      base_code   = encode_keys(pressed[BTN_LEFT], pressed[BTN_RIGHT]);
      decide_next = pressed[BTN_DECIDE];
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REPEAT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW = $clog2(REPEAT_MAX + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_CYCLES - 1);

  key_code_t     held_reg;
  key_code_t     held_next;
  logic [TW-1:0] timer_reg;
  logic [TW-1:0] timer_next;
  logic [GW-1:0] gap_reg;
  logic [GW-1:0] gap_next;
  logic          in_gap_reg;
  logic          in_gap_next;
  logic          repeated_reg;
  logic          repeated_next;

  // Repeat shaping: count cycles a code is held, then insert a short 00 gap
  // so the menu sees a fresh 00->code edge. Any code change restarts it.
  always_comb begin
    key_next      = base_code;
    held_next     = base_code;
    timer_next    = '0;
    gap_next      = '0;
    in_gap_next   = 1'b0;
    repeated_next = 1'b0;
    if ((base_code != KEY_NONE) && (base_code == held_reg)) begin
      repeated_next = repeated_reg;
      if (in_gap_reg) begin
        key_next    = KEY_NONE;
        in_gap_next = 1'b1;
        gap_next    = gap_reg + GW'(1);
        if (gap_reg == GAP_LAST) begin
          key_next      = base_code;
          in_gap_next   = 1'b0;
          gap_next      = '0;
          repeated_next = 1'b1;
        end
      end else if (timer_reg == (repeated_reg ? PERIOD_LAST : DELAY_LAST)) begin
        key_next    = KEY_NONE;
        in_gap_next = 1'b1;
      end else begin
        timer_next = timer_reg + TW'(1);
      end
    end
  end

  // Repeat timer state
  always_ff @(posedge clk) begin
    if (rst) begin
      held_reg     <= KEY_NONE;
      timer_reg    <= '0;
      gap_reg      <= '0;
      in_gap_reg   <= 1'b0;
      repeated_reg <= 1'b0;
    end else begin
      held_reg     <= held_next;
      timer_reg    <= timer_next;
      gap_reg      <= gap_next;
      in_gap_reg   <= in_gap_next;
      repeated_reg <= repeated_next;
    end
  end
`else
  // Without auto-repeat a held direction produces one edge only
  assign key_next = base_code;
`endif

  // Output registers: no combinational path from any pin to the menu
  always_ff @(posedge clk) begin
    if (rst) begin
      key_reg    <= KEY_NONE;
      decide_reg <= 1'b0;
    end else begin
      key_reg    <= key_next;
      decide_reg <= decide_next;
    end
  end

  assign key_input_out = key_reg;
  assign decide_out    = decide_reg;

endmodule

// File: tb/tb_menu_input_ctrl.sv
// Scoreboard bench for menu_input_ctrl: stimulus pushes the expected output
// changes (cycle, key, decide); a monitor compares every observed change.
module tb_menu_input_ctrl;
  import menu_input_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      btn_left;
  logic      btn_right;
  logic      btn_decide;
  logic      enable;
  key_code_t key;
  logic      decide;

  menu_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (10),
    .GAP_CYCLES     (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_left_in  (btn_left),
    .btn_right_in (btn_right),
    .btn_decide_in(btn_decide),
    .enable_in    (enable),
    .key_input_out(key),
    .decide_out   (decide)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] key;
    logic       dec;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  bit   stim_done = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic expect_ev(input int c, input logic [1:0] k, input logic d, input string tag);
    exp_t e;
    e.cyc = c;
    e.key = k;
    e.dec = d;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Inputs change 1 time unit after posedge number c
  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stimulus: every raw edge at cycle c shows up at the output at c+7
  initial begin
    rst = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_decide = 1'b0; enable = 1'b1;
    at_cycle(3);  rst = 1'b0;

    // Clean right press and release
    at_cycle(10); btn_right = 1'b1; expect_ev(17, KEY_RIGHT, 1'b0, "right_press");
    at_cycle(30); btn_right = 1'b0; expect_ev(37, KEY_NONE, 1'b0, "right_release");

    // Bouncing right: never stable long enough, no expected change
    for (int k = 0; k < 10; k++) begin
      at_cycle(50 + 2 * k);
      btn_right = (k % 2 == 0);
    end
    at_cycle(70); btn_right = 1'b0;

    // Left, then both, then left alone again
    at_cycle(80);  btn_left  = 1'b1; expect_ev(87,  KEY_LEFT, 1'b0, "left_press");
    at_cycle(90);  btn_right = 1'b1; expect_ev(97,  KEY_NONE, 1'b0, "both_pressed");
    at_cycle(110); btn_right = 1'b0; expect_ev(117, KEY_LEFT, 1'b0, "right_off_left_held");
    at_cycle(125); btn_left  = 1'b0; expect_ev(132, KEY_NONE, 1'b0, "left_release");

    // Decide held while disabled must not count when the menu opens
    at_cycle(140); enable = 1'b0;
    at_cycle(145); btn_decide = 1'b1;
    at_cycle(160); enable = 1'b1;
    at_cycle(170); btn_decide = 1'b0;
    at_cycle(185); btn_decide = 1'b1; expect_ev(192, KEY_NONE, 1'b1, "decide_press");
    at_cycle(200); btn_decide = 1'b0; expect_ev(207, KEY_NONE, 1'b0, "decide_release");

    // Disable while right reported, re-enable while still held
    at_cycle(210); btn_right = 1'b1; expect_ev(217, KEY_RIGHT, 1'b0, "right_press2");
    at_cycle(225); enable = 1'b0;    expect_ev(226, KEY_NONE, 1'b0, "disable_forces_idle");
    at_cycle(230); enable = 1'b1;
    at_cycle(235); btn_right = 1'b0;

    // Reset pulse mid-press: held button must be released and re-pressed
    at_cycle(250); btn_right = 1'b1; expect_ev(257, KEY_RIGHT, 1'b0, "right_press3");
    at_cycle(265); rst = 1'b1;       expect_ev(266, KEY_NONE, 1'b0, "reset_mid_press");
    at_cycle(266); rst = 1'b0;
    at_cycle(285); btn_right = 1'b0;
    at_cycle(300); btn_right = 1'b1; expect_ev(307, KEY_RIGHT, 1'b0, "repress_after_reset");
    at_cycle(315); btn_right = 1'b0; expect_ev(322, KEY_NONE, 1'b0, "release_after_reset");

    // Long hold: first 01 at 347, held 60 cycles
    at_cycle(340); btn_right = 1'b1; expect_ev(347, KEY_RIGHT, 1'b0, "long_hold_press");
`ifdef AUTO_REPEAT_EN
    for (int g = 0; g < 4; g++) begin
      expect_ev(367 + 12 * g, KEY_NONE,  1'b0, "repeat_gap");
      expect_ev(369 + 12 * g, KEY_RIGHT, 1'b0, "repeat_reassert");
    end
`endif
    at_cycle(407); btn_right = 1'b0; expect_ev(414, KEY_NONE, 1'b0, "long_hold_release");

    at_cycle(430); stim_done = 1'b1;
  end

  // Monitor: every output change must match the next scoreboard entry
  initial begin
    logic [1:0] prev_key;
    logic       prev_dec;
    exp_t       e;
    prev_key = 2'b00;
    prev_dec = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc == 2) begin
        checks++;
        if (key !== KEY_NONE || decide !== 1'b0) begin
          failures++;
          $display("FAIL reset_state: got key=%b decide=%b, required key=00 decide=0", key, decide);
        end else begin
          $display("reset_state: key=%b decide=%b", key, decide);
        end
        prev_key = key;
        prev_dec = decide;
      end else if (cyc > 2) begin
        if (key !== prev_key || decide !== prev_dec) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change: cycle=%0d key=%b decide=%b, required no change", cyc, key, decide);
          end else begin
            e = exp_q.pop_front();
            if (cyc != e.cyc || key !== e.key || decide !== e.dec) begin
              failures++;
              $display("FAIL %s: got cycle=%0d key=%b decide=%b, required cycle=%0d key=%b decide=%b",
                       e.tag, cyc, key, decide, e.cyc, e.key, e.dec);
            end else begin
              $display("%s: cycle=%0d key=%b decide=%b", e.tag, cyc, key, decide);
            end
          end
        end
        prev_key = key;
        prev_dec = decide;
      end
      if (stim_done) begin
        checks++;
        if (exp_q.size() != 0) begin
          failures++;
          e = exp_q[0];
          $display("FAIL missing_events: %0d pending, first %s at cycle %0d, required 0 pending",
                   exp_q.size(), e.tag, e.cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
      if (cyc > 2000) begin
        failures++;
        $display("FAIL timeout: cycle=%0d, required stimulus done by 430", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

endmodule
